// File: rtl/dso_pkg.sv
// Shared types and S2MM command-word layout for the DSO capture path.
package dso_pkg;

  localparam int unsigned CMD_W     = 72;
  localparam int unsigned BTT_W     = 23;
  localparam int unsigned SADDR_W   = 32;
  localparam int unsigned TAG_W     = 4;

  localparam int unsigned BTT_OFF   = 0;
  localparam int unsigned TYPE_OFF  = 23;
  localparam int unsigned EOF_OFF   = 30;
  localparam int unsigned SADDR_OFF = 32;
  localparam int unsigned TAG_OFF   = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

endpackage

// File: rtl/s2mm_cmd_scheduler_if.sv
// S2MM command channel plus completion/error/halt sideband to the DataMover.
interface s2mm_cmd_scheduler_if;
  import dso_pkg::*;

  logic             cmd_tvalid;
  logic             cmd_tready;
  logic [CMD_W-1:0] cmd_tdata;
  logic             wr_xfer_cmplt;
  logic             s2mm_err;
  logic             s2mm_halt;

  modport master (
    output cmd_tvalid, cmd_tdata, s2mm_halt,
    input  cmd_tready, wr_xfer_cmplt, s2mm_err
  );

  modport slave (
    input  cmd_tvalid, cmd_tdata, s2mm_halt,
    output cmd_tready, wr_xfer_cmplt, s2mm_err
  );

endinterface

// File: rtl/s2mm_cmd_pack.sv
// Combinational packer: ring index, base and BTT into one 72-bit S2MM command.
module s2mm_cmd_pack
  import dso_pkg::*;
#(
  parameter int unsigned IDX_W = 10
) (
  input  logic [IDX_W-1:0]   index,
  input  logic [SADDR_W-1:0] base,
  input  logic [BTT_W-1:0]   btt,
  output logic [CMD_W-1:0]   cmd_c
);

  logic [SADDR_W-1:0] saddr;

  assign saddr = base + SADDR_W'(index) * SADDR_W'(btt);

  always_comb begin
    cmd_c                        = '0;
    cmd_c[BTT_OFF +: BTT_W]      = btt;
    cmd_c[TYPE_OFF]              = 1'b1;
    cmd_c[EOF_OFF]               = 1'b1;
    cmd_c[SADDR_OFF +: SADDR_W]  = saddr;
    cmd_c[TAG_OFF +: TAG_W]      = TAG_W'(index);
  end

endmodule

// File: rtl/s2mm_cmd_scheduler.sv
// Issues fixed-size ring-buffer write commands to the S2MM DataMover, bounds
// commands in flight, counts completions and latches DataMover errors.
module s2mm_cmd_scheduler
  import dso_pkg::*;
#(
  parameter logic [31:0]  BUF_BASE    = 32'h0000_0000,
  parameter logic [22:0]  CHUNK_BYTES = 23'd8192,
  parameter int unsigned  NUM_CHUNKS  = 1024,
  parameter int unsigned  MAX_OUT     = 4,
  localparam int unsigned IDX_W       = $clog2(NUM_CHUNKS)
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  input  logic                    run,
  s2mm_cmd_scheduler_if.master    cmd,
  output logic                    busy,
  output logic                    err_latched,
  output logic [31:0]             chunk_done,
  output logic [IDX_W-1:0]        wr_index
);

  localparam int unsigned OUT_W = 4;

  state_t             state, state_d;
  logic [OUT_W-1:0]   outstanding, outstanding_d, out_nxt;
  logic [IDX_W-1:0]   wr_index_d;
  logic [31:0]        chunk_done_d;
  logic [CMD_W-1:0]   tdata_d, packed_c;
  logic               valid_d, halt_d, busy_d, err_d;
  logic               hs_c, cmplt_ok_c, spurious_c, err_exit_c;

  assign hs_c       = cmd.cmd_tvalid && cmd.cmd_tready;
  assign cmplt_ok_c = cmd.wr_xfer_cmplt && (outstanding != '0);
  assign spurious_c = cmd.wr_xfer_cmplt && (outstanding == '0);
  assign err_exit_c = (state == ST_ERROR) && (state_d == ST_IDLE);

  s2mm_cmd_pack #(.IDX_W(IDX_W)) u_pack (
    .index (wr_index_d),
    .base  (BUF_BASE),
    .btt   (CHUNK_BYTES),
    .cmd_c (packed_c)
  );

  // State register
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state <= ST_IDLE;
    else              state <= state_d;
  end

  // Datapath next values that the state decision depends on
  always_comb begin
    out_nxt    = outstanding;
    wr_index_d = wr_index;
    valid_d    = 1'b0;
    case ({hs_c, cmplt_ok_c})
      2'b10:   out_nxt = outstanding + OUT_W'(1);
      2'b01:   out_nxt = outstanding - OUT_W'(1);
      default: out_nxt = outstanding;
    endcase
    if (hs_c) begin
      wr_index_d = (wr_index == IDX_W'(NUM_CHUNKS - 1)) ? '0 : wr_index + IDX_W'(1);
    end
    // An offered command is held until accepted; only an error may retract it
    case (state)
      ST_ISSUE: valid_d = run ? (out_nxt < OUT_W'(MAX_OUT))
                              : (cmd.cmd_tvalid && !cmd.cmd_tready);
      ST_DRAIN: valid_d = cmd.cmd_tvalid && !cmd.cmd_tready;
      default:  valid_d = 1'b0;
    endcase
    if (cmd.s2mm_err) valid_d = 1'b0;
  end

  // Next-state logic; a DataMover error overrides every other transition
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (run) state_d = ST_ISSUE;
      ST_ISSUE: if (!run) state_d = ST_DRAIN;
      ST_DRAIN: if ((out_nxt == '0) && !valid_d) state_d = ST_IDLE;
      ST_ERROR: if (!run) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (cmd.s2mm_err) state_d = ST_ERROR;
  end

  // Output / counter next values
  always_comb begin
    outstanding_d = err_exit_c ? '0 : out_nxt;
    halt_d        = (state_d == ST_ERROR);
    busy_d        = (state_d != ST_IDLE);
    tdata_d       = valid_d ? packed_c : cmd.cmd_tdata;
    chunk_done_d  = chunk_done;
    if ((state == ST_IDLE) && (state_d == ST_ISSUE)) chunk_done_d = '0;
    else if (cmplt_ok_c)                             chunk_done_d = chunk_done + 32'd1;
    err_d = err_latched;
    if (err_exit_c)                             err_d = 1'b0;
    if ((state_d == ST_ERROR) || spurious_c)    err_d = 1'b1;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      outstanding    <= '0;
      wr_index       <= '0;
      chunk_done     <= '0;
      err_latched    <= 1'b0;
      busy           <= 1'b0;
      cmd.cmd_tvalid <= 1'b0;
      cmd.cmd_tdata  <= '0;
      cmd.s2mm_halt  <= 1'b0;
    end else begin
      outstanding    <= outstanding_d;
      wr_index       <= wr_index_d;
      chunk_done     <= chunk_done_d;
      err_latched    <= err_d;
      busy           <= busy_d;
      cmd.cmd_tvalid <= valid_d;
      cmd.cmd_tdata  <= tdata_d;
      cmd.s2mm_halt  <= halt_d;
    end
  end

endmodule

// File: tb/tb_s2mm_cmd_scheduler.sv
// Directed bench for s2mm_cmd_scheduler: 4-chunk ring, two commands in flight.
module tb_s2mm_cmd_scheduler;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        busy;
  logic        err_latched;
  logic [31:0] chunk_done;
  logic [1:0]  wr_index;

  int          checks = 0;
  int          errs   = 0;
  int          hs_cnt = 0;
  int          base_cnt;
  logic [31:0] hs_addr[$];

  s2mm_cmd_scheduler_if cmd_if ();

  s2mm_cmd_scheduler #(
    .BUF_BASE    (32'h0000_0000),
    .CHUNK_BYTES (23'd8192),
    .NUM_CHUNKS  (4),
    .MAX_OUT     (2)
  ) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .run         (run),
    .cmd         (cmd_if),
    .busy        (busy),
    .err_latched (err_latched),
    .chunk_done  (chunk_done),
    .wr_index    (wr_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every handshake that the coming rising edge will accept
  always @(negedge clk) begin
    if (rst_n && cmd_if.cmd_tvalid && cmd_if.cmd_tready) begin
      hs_cnt = hs_cnt + 1;
      hs_addr.push_back(cmd_if.cmd_tdata[63:32]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] exp_cmd(input int idx);
    logic [31:0] sa;
    logic [3:0]  tg;
    sa = 32'(idx) * 32'd8192;
    tg = 4'(idx);
    return {4'h0, tg, sa, 1'b0, 1'b1, 6'h00, 1'b1, 23'd8192};
  endfunction

  function automatic logic [31:0] addr_at(input int i);
    if (i < hs_addr.size()) return hs_addr[i];
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    cmd_if.cmd_tready    = 1'b0;
    cmd_if.wr_xfer_cmplt = 1'b0;
    cmd_if.s2mm_err      = 1'b0;
    repeat (3) tick();

    chk("rst_tvalid", 72'(cmd_if.cmd_tvalid), 72'd0);
    chk("rst_tdata",  cmd_if.cmd_tdata,        72'd0);
    chk("rst_halt",   72'(cmd_if.s2mm_halt),   72'd0);
    chk("rst_busy",   72'(busy),               72'd0);
    chk("rst_err",    72'(err_latched),        72'd0);
    chk("rst_done",   72'(chunk_done),         72'd0);
    chk("rst_index",  72'(wr_index),           72'd0);
    rst_n = 1'b1;
    tick();

    // Basic issue: two commands then the in-flight limit holds tvalid low
    cmd_if.cmd_tready = 1'b1;
    run = 1'b1;
    tick();
    chk("lat_valid_c1", 72'(cmd_if.cmd_tvalid), 72'd0);
    chk("lat_busy_c1",  72'(busy),              72'd1);
    tick();
    chk("lat_valid_c2", 72'(cmd_if.cmd_tvalid), 72'd1);
    chk("first_word",   cmd_if.cmd_tdata,       exp_cmd(0));
    repeat (6) tick();
    chk("basic_hs_cnt", 72'(hs_cnt),            72'd2);
    chk("basic_valid",  72'(cmd_if.cmd_tvalid), 72'd0);
    chk("basic_index",  72'(wr_index),          72'd2);

    // Four completions each free one slot for a new command
    for (int i = 0; i < 4; i++) begin
      cmd_if.wr_xfer_cmplt = 1'b1;
      tick();
      cmd_if.wr_xfer_cmplt = 1'b0;
      repeat (3) tick();
    end
    chk("wrap_hs_cnt", 72'(hs_cnt),            72'd6);
    chk("wrap_valid",  72'(cmd_if.cmd_tvalid), 72'd0);

    // Stop with two outstanding and drain
    run = 1'b0;
    tick();
    chk("drain_busy", 72'(busy), 72'd1);
    cmd_if.wr_xfer_cmplt = 1'b1;
    tick();
    cmd_if.wr_xfer_cmplt = 1'b0;
    repeat (2) tick();
    chk("drain_busy_mid", 72'(busy),       72'd1);
    chk("drain_done_5",   72'(chunk_done), 72'd5);
    cmd_if.wr_xfer_cmplt = 1'b1;
    chk("drain_busy_pre", 72'(busy), 72'd1);
    tick();
    cmd_if.wr_xfer_cmplt = 1'b0;
    chk("drain_busy_fall", 72'(busy),       72'd0);
    chk("drain_done_6",    72'(chunk_done), 72'd6);
    chk("drain_index",     72'(wr_index),   72'd2);
    chk("drain_no_issue",  72'(hs_cnt),     72'd6);
    chk("addr0", 72'(addr_at(0)), 72'd0);
    chk("addr1", 72'(addr_at(1)), 72'd8192);
    chk("addr2", 72'(addr_at(2)), 72'd16384);
    chk("addr3", 72'(addr_at(3)), 72'd24576);
    chk("addr4", 72'(addr_at(4)), 72'd0);
    chk("addr5", 72'(addr_at(5)), 72'd8192);

    // Backpressure: word held stable while tready is low
    cmd_if.cmd_tready = 1'b0;
    run = 1'b1;
    repeat (2) tick();
    chk("restart_clear", 72'(chunk_done), 72'd0);
    base_cnt = hs_cnt;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 72'(cmd_if.cmd_tvalid), 72'd1);
      chk("bp_word",  cmd_if.cmd_tdata,       exp_cmd(2));
      tick();
    end
    cmd_if.cmd_tready = 1'b1;
    tick();
    cmd_if.cmd_tready = 1'b0;
    chk("bp_next_word", cmd_if.cmd_tdata, exp_cmd(3));
    chk("bp_index",     72'(wr_index),    72'd3);
    repeat (2) tick();
    chk("bp_single_hs", 72'(hs_cnt - base_cnt),  72'd1);
    chk("bp_valid_hold", 72'(cmd_if.cmd_tvalid), 72'd1);

    // Handshake and completion together: one slot remains free afterwards
    base_cnt = hs_cnt;
    cmd_if.cmd_tready    = 1'b1;
    cmd_if.wr_xfer_cmplt = 1'b1;
    tick();
    cmd_if.wr_xfer_cmplt = 1'b0;
    chk("sim_done",  72'(chunk_done),         72'd1);
    chk("sim_valid", 72'(cmd_if.cmd_tvalid),  72'd1);
    repeat (4) tick();
    chk("sim_hs_cnt",  72'(hs_cnt - base_cnt),  72'd2);
    chk("sim_full",    72'(cmd_if.cmd_tvalid),  72'd0);
    chk("sim_index",   72'(wr_index),           72'd1);

    // Error while a command is being offered
    cmd_if.cmd_tready    = 1'b0;
    cmd_if.wr_xfer_cmplt = 1'b1;
    tick();
    cmd_if.wr_xfer_cmplt = 1'b0;
    chk("err_pre_valid", 72'(cmd_if.cmd_tvalid), 72'd1);
    cmd_if.s2mm_err = 1'b1;
    tick();
    chk("err_halt",  72'(cmd_if.s2mm_halt),  72'd1);
    chk("err_valid", 72'(cmd_if.cmd_tvalid), 72'd0);
    chk("err_flag",  72'(err_latched),       72'd1);
    chk("err_busy",  72'(busy),              72'd1);
    tick();
    cmd_if.s2mm_err = 1'b0;
    tick();
    chk("err_hold_run", 72'(cmd_if.s2mm_halt), 72'd1);
    run = 1'b0;
    tick();
    chk("clr_halt", 72'(cmd_if.s2mm_halt), 72'd0);
    chk("clr_flag", 72'(err_latched),      72'd0);
    chk("clr_busy", 72'(busy),             72'd0);

    // Completion with nothing outstanding: sticky flag, no ERROR entry
    cmd_if.wr_xfer_cmplt = 1'b1;
    tick();
    cmd_if.wr_xfer_cmplt = 1'b0;
    chk("spur_flag", 72'(err_latched),       72'd1);
    chk("spur_halt", 72'(cmd_if.s2mm_halt),  72'd0);
    chk("spur_busy", 72'(busy),              72'd0);

    // Error exit cleared outstanding, so a full window issues again
    base_cnt = hs_cnt;
    cmd_if.cmd_tready = 1'b1;
    run = 1'b1;
    repeat (8) tick();
    chk("rerun_hs_cnt", 72'(hs_cnt - base_cnt), 72'd2);
    chk("rerun_index",  72'(wr_index),          72'd3);
    chk("rerun_sticky", 72'(err_latched),       72'd1);

    // Asynchronous reset in the middle of DRAIN
    run = 1'b0;
    tick();
    chk("pre_rst_busy", 72'(busy), 72'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 72'(cmd_if.cmd_tvalid), 72'd0);
    chk("arst_tdata",  cmd_if.cmd_tdata,        72'd0);
    chk("arst_halt",   72'(cmd_if.s2mm_halt),   72'd0);
    chk("arst_busy",   72'(busy),               72'd0);
    chk("arst_err",    72'(err_latched),        72'd0);
    chk("arst_done",   72'(chunk_done),         72'd0);
    chk("arst_index",  72'(wr_index),           72'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
